// File: rtl/rect_fill_pkg.sv
// rect_fill_pkg
//   Shared definitions for the rectangle fill engine: coordinate width,
//   full write mask and the engine state encoding.
package rect_fill_pkg;

  localparam int CORDW = 12;
  localparam logic [3:0] VRAM_MASK_FULL = 4'b1111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLIP = 3'd1,
    REQ  = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } fill_state_e;

endpackage

// File: rtl/rect_fill_addr_gen.sv
// rect_fill_addr_gen
//   Raster-order pixel walker for the fill engine. Holds the current x/y and
//   a running row base (y * FB_WIDTH) kept by accumulation, so no multiplier
//   is needed in the per-pixel path.
// Ports
//   clk_pix, reset   pixel clock, synchronous active-high reset
//   load             capture start corner and clipped end corner
//   step             advance to the next pixel in raster order
//   x0, y0, x1, y1   rectangle corners (x1/y1 already clipped)
//   addr             pixel index of the current pixel (row_base + x)
//   last             current pixel is the bottom-right corner
module rect_fill_addr_gen
  import rect_fill_pkg::*;
#(
  parameter int FB_WIDTH = 640
) (
  input  logic             clk_pix,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [CORDW-1:0] x0,
  input  logic [CORDW-1:0] y0,
  input  logic [CORDW-1:0] x1,
  input  logic [CORDW-1:0] y1,
  output logic [31:0]      addr,
  output logic             last
);

  localparam logic [31:0] ROW_STEP = 32'(FB_WIDTH);

  logic [CORDW-1:0] x_cur, y_cur, x_start, x_end, y_end;
  logic [31:0]      row_base;

  // y * FB_WIDTH as a sum of constant shifts of y; FB_WIDTH is fixed at
  // elaboration so this reduces to a small adder tree, done in one cycle.
  function automatic logic [31:0] row_of(input logic [CORDW-1:0] y);
    logic [31:0] acc;
    acc = '0;
    for (int b = 0; b < 32; b++) begin
      if (((FB_WIDTH >> b) & 1) == 1)
        acc = acc + ({{(32-CORDW){1'b0}}, y} << b);
    end
    return acc;
  endfunction

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      x_cur    <= '0;
      y_cur    <= '0;
      x_start  <= '0;
      x_end    <= '0;
      y_end    <= '0;
      row_base <= '0;
    end else if (load) begin
      x_cur    <= x0;
      y_cur    <= y0;
      x_start  <= x0;
      x_end    <= x1;
      y_end    <= y1;
      row_base <= row_of(y0);
    end else if (step) begin
      if (x_cur == x_end) begin
        x_cur    <= x_start;
        y_cur    <= y_cur + 1'b1;
        row_base <= row_base + ROW_STEP;
      end else begin
        x_cur <= x_cur + 1'b1;
      end
    end
  end

  assign addr = row_base + {{(32-CORDW){1'b0}}, x_cur};
  assign last = (x_cur == x_end) && (y_cur == y_end);

endmodule

// File: rtl/rect_fill_engine.sv
// rect_fill_engine
//   Fills an inclusive rectangle of a FB_WIDTH x FB_HEIGHT framebuffer with a
//   single colour, one 16-bit pixel write per vram handshake, raster order.
//   Optional feature: define RECT_FILL_ABORT_EN to add abort_i.
//
//   state | meaning
//   IDLE  | ready for a command
//   CLIP  | clamp corners to the framebuffer, load the address generator
//   REQ   | write request held until vram_ack_i
//   GAP   | one idle cycle between writes
//   DONE  | one-cycle completion pulse
//
// Ports
//   clk_pix, reset              pixel clock, synchronous active-high reset
//   abort_i                     (RECT_FILL_ABORT_EN only) stop the fill early
//   cmd_valid_i / cmd_ready_o   command handshake
//   cmd_x0_i..cmd_y1_i          inclusive corners, cmd_color_i fill colour
//   busy_o, done_o              status, one-cycle completion pulse
//   vram_*                      framebuffer write port
module rect_fill_engine
  import rect_fill_pkg::*;
#(
  parameter int FB_WIDTH  = 640,
  parameter int FB_HEIGHT = 480
) (
  input  logic             clk_pix,
  input  logic             reset,
`ifdef RECT_FILL_ABORT_EN
  input  logic             abort_i,
`endif
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [CORDW-1:0] cmd_x0_i,
  input  logic [CORDW-1:0] cmd_y0_i,
  input  logic [CORDW-1:0] cmd_x1_i,
  input  logic [CORDW-1:0] cmd_y1_i,
  input  logic [15:0]      cmd_color_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             vram_sel_o,
  output logic             vram_wr_o,
  output logic [3:0]       vram_mask_o,
  output logic [31:0]      vram_addr_o,
  output logic [15:0]      vram_data_out_o,
  input  logic             vram_ack_i
);

  localparam logic [CORDW-1:0] X_MAX = CORDW'(FB_WIDTH - 1);
  localparam logic [CORDW-1:0] Y_MAX = CORDW'(FB_HEIGHT - 1);

  fill_state_e      state, state_nx;
  logic [CORDW-1:0] x0_q, y0_q, x1_q, y1_q;
  logic [15:0]      color_q;
  logic [CORDW-1:0] x1_clip, y1_clip;
  logic             empty;
  logic             accept;
  logic             gen_load, gen_step;
  logic [31:0]      gen_addr;
  logic             gen_last;
  logic             in_req;

  assign accept  = cmd_valid_i && (state == IDLE);
  assign x1_clip = (x1_q > X_MAX) ? X_MAX : x1_q;
  assign y1_clip = (y1_q > Y_MAX) ? Y_MAX : y1_q;
  // x0 beyond the right edge also lands here because x1_clip <= X_MAX.
  assign empty   = (x0_q > x1_clip) || (y0_q > y1_clip);

`ifdef RECT_FILL_ABORT_EN
  // Remembers an abort seen during a write so the outstanding ack is still
  // consumed before finishing.
  logic abort_pend;
  logic abort_any;

  always_ff @(posedge clk_pix) begin
    if (reset || state == IDLE) abort_pend <= 1'b0;
    else if (abort_i)           abort_pend <= 1'b1;
  end

  assign abort_any = abort_i || abort_pend;
`endif

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      state   <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        x0_q    <= cmd_x0_i;
        y0_q    <= cmd_y0_i;
        x1_q    <= cmd_x1_i;
        y1_q    <= cmd_y1_i;
        color_q <= cmd_color_i;
      end
    end
  end

  always_comb begin
    state_nx = state;
    gen_load = 1'b0;
    gen_step = 1'b0;
    case (state)
      IDLE: if (cmd_valid_i) state_nx = CLIP;
      CLIP: begin
        gen_load = 1'b1;
        state_nx = empty ? DONE : REQ;
`ifdef RECT_FILL_ABORT_EN
        if (abort_any) state_nx = DONE;
`endif
      end
      REQ: begin
        if (vram_ack_i) begin
          gen_step = 1'b1;
          state_nx = gen_last ? DONE : GAP;
`ifdef RECT_FILL_ABORT_EN
          if (abort_any) state_nx = DONE;
`endif
        end
      end
      GAP: begin
        state_nx = REQ;
`ifdef RECT_FILL_ABORT_EN
        if (abort_any) state_nx = DONE;
`endif
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  rect_fill_addr_gen #(
    .FB_WIDTH(FB_WIDTH)
  ) u_addr_gen (
    .clk_pix (clk_pix),
    .reset   (reset),
    .load    (gen_load),
    .step    (gen_step),
    .x0      (x0_q),
    .y0      (y0_q),
    .x1      (x1_clip),
    .y1      (y1_clip),
    .addr    (gen_addr),
    .last    (gen_last)
  );

  // Write port is driven only in REQ and reads zero otherwise.
  assign in_req          = (state == REQ);
  assign cmd_ready_o     = (state == IDLE);
  assign busy_o          = (state != IDLE);
  assign done_o          = (state == DONE);
  assign vram_sel_o      = in_req;
  assign vram_wr_o       = in_req;
  assign vram_mask_o     = in_req ? VRAM_MASK_FULL : 4'b0000;
  assign vram_addr_o     = in_req ? gen_addr : 32'd0;
  assign vram_data_out_o = in_req ? color_q : 16'd0;

endmodule

// File: tb/tb_rect_fill_engine.sv
module tb_rect_fill_engine;

  logic        clk_pix;
  logic        reset;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [11:0] cmd_x0_i, cmd_y0_i, cmd_x1_i, cmd_y1_i;
  logic [15:0] cmd_color_i;
  logic        busy_o, done_o;
  logic        vram_sel_o, vram_wr_o;
  logic [3:0]  vram_mask_o;
  logic [31:0] vram_addr_o;
  logic [15:0] vram_data_out_o;
  logic        vram_ack_i;
`ifdef RECT_FILL_ABORT_EN
  logic        abort;
`endif

  int tests;
  int fails;

  rect_fill_engine #(.FB_WIDTH(640), .FB_HEIGHT(480)) dut (
    .clk_pix         (clk_pix),
    .reset           (reset),
`ifdef RECT_FILL_ABORT_EN
    .abort_i         (abort),
`endif
    .cmd_valid_i     (cmd_valid_i),
    .cmd_ready_o     (cmd_ready_o),
    .cmd_x0_i        (cmd_x0_i),
    .cmd_y0_i        (cmd_y0_i),
    .cmd_x1_i        (cmd_x1_i),
    .cmd_y1_i        (cmd_y1_i),
    .cmd_color_i     (cmd_color_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .vram_sel_o      (vram_sel_o),
    .vram_wr_o       (vram_wr_o),
    .vram_mask_o     (vram_mask_o),
    .vram_addr_o     (vram_addr_o),
    .vram_data_out_o (vram_data_out_o),
    .vram_ack_i      (vram_ack_i)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  typedef struct {
    logic [11:0] x0, y0, x1, y1;
    logic [15:0] col;
    int          delay;
    bit          stray;
    int          exp_n;
    longint      exp_sum;
    longint      exp_first;
    longint      exp_last;
  } vec_t;

  typedef struct {
    int     nwr;
    int     dones;
    int     bad_hold;
    int     bad_gap;
    int     bad_data;
    int     sel_lat;
    int     done_lat;
    longint sum;
    longint first;
    longint last;
    bit     timeout;
  } res_t;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, cmd_ready_o, 1);
    check({tag, "_busy"},  busy_o, 0);
    check({tag, "_done"},  done_o, 0);
    check({tag, "_sel"},   vram_sel_o, 0);
    check({tag, "_wr"},    vram_wr_o, 0);
    check({tag, "_mask"},  vram_mask_o, 0);
    check({tag, "_addr"},  vram_addr_o, 0);
    check({tag, "_data"},  vram_data_out_o, 0);
  endtask

  // Issues one command from IDLE and plays the vram slave: ack after the
  // request has been held delay+1 cycles, optional stray ack outside REQ.
  task automatic run_cmd(input vec_t v, input int abort_at, output res_t r);
    int k, sel_cnt, gap_state, done_k;
    logic [31:0] h_addr;
    logic [15:0] h_data;
    r.nwr = 0; r.dones = 0; r.bad_hold = 0; r.bad_gap = 0; r.bad_data = 0;
    r.sel_lat = -1; r.done_lat = -1; r.sum = 0; r.first = -1; r.last = -1;
    r.timeout = 1'b1;
    sel_cnt = 0; gap_state = 0; done_k = -1;
    h_addr = '0; h_data = '0;
    cmd_x0_i = v.x0; cmd_y0_i = v.y0; cmd_x1_i = v.x1; cmd_y1_i = v.y1;
    cmd_color_i = v.col; cmd_valid_i = 1'b1; vram_ack_i = v.stray;
    @(posedge clk_pix); #1;
    cmd_valid_i = 1'b0;
    k = 1;
    for (int n = 0; n < 4000; n++) begin
      if (done_o) begin
        r.dones++;
        if (done_k < 0) begin done_k = k; r.done_lat = k; end
      end
      if (gap_state == 1) begin
        if (vram_sel_o) r.bad_gap++;
        gap_state = done_o ? 0 : 2;
      end else if (gap_state == 2) begin
        if (!vram_sel_o) r.bad_gap++;
        gap_state = 0;
      end
`ifdef RECT_FILL_ABORT_EN
      abort = 1'b0;
`endif
      if (vram_sel_o) begin
        if (r.sel_lat < 0) r.sel_lat = k;
        if (sel_cnt == 0) begin
          h_addr = vram_addr_o;
          h_data = vram_data_out_o;
`ifdef RECT_FILL_ABORT_EN
          if (abort_at > 0 && r.nwr == abort_at - 1) abort = 1'b1;
`endif
        end else if (vram_addr_o !== h_addr || vram_data_out_o !== h_data) begin
          r.bad_hold++;
        end
        if (vram_data_out_o !== v.col || vram_wr_o !== 1'b1 || vram_mask_o !== 4'hF)
          r.bad_data++;
        sel_cnt++;
        if (sel_cnt == v.delay + 1) begin
          vram_ack_i = 1'b1;
          sel_cnt = 0;
          if (r.nwr == 0) r.first = vram_addr_o;
          r.last = vram_addr_o;
          r.sum += vram_addr_o;
          r.nwr++;
          gap_state = 1;
        end else begin
          vram_ack_i = 1'b0;
        end
      end else begin
        vram_ack_i = v.stray;
      end
      if (done_k >= 0 && k >= done_k + 3) begin
        r.timeout = 1'b0;
        break;
      end
      @(posedge clk_pix); #1;
      k++;
    end
    vram_ack_i = 1'b0;
`ifdef RECT_FILL_ABORT_EN
    abort = 1'b0;
`endif
  endtask

  vec_t vecs[8];
  res_t r;

  initial begin
    int cnt, dn, nwr, drop;
    bit found;
    longint a0, a1;
    tests = 0;
    fails = 0;

    vecs[0] = '{12'd0,   12'd0,   12'd1,    12'd1,    16'h0F00, 1, 1'b0, 4,   1282,      0,      641};
    vecs[1] = '{12'd638, 12'd479, 12'd700,  12'd600,  16'h0ABC, 0, 1'b0, 2,   614397,    307198, 307199};
    vecs[2] = '{12'd10,  12'd5,   12'd3,    12'd5,    16'h0123, 0, 1'b0, 0,   0,         -1,     -1};
    vecs[3] = '{12'd5,   12'd2,   12'd7,    12'd3,    16'h0FFF, 5, 1'b0, 6,   9636,      1285,   1927};
    vecs[4] = '{12'd639, 12'd477, 12'd639,  12'd479,  16'h0555, 2, 1'b1, 3,   919677,    305919, 307199};
    vecs[5] = '{12'd0,   12'd479, 12'd4095, 12'd4095, 16'h0A5A, 0, 1'b0, 640, 196402880, 306560, 307199};
    vecs[6] = '{12'd640, 12'd0,   12'd650,  12'd10,   16'h0777, 0, 1'b1, 0,   0,         -1,     -1};
    vecs[7] = '{12'd3,   12'd3,   12'd3,    12'd3,    16'h0F0F, 3, 1'b1, 1,   1923,      1923,   1923};

    reset = 1'b1; cmd_valid_i = 1'b0; vram_ack_i = 1'b0;
    cmd_x0_i = '0; cmd_y0_i = '0; cmd_x1_i = '0; cmd_y1_i = '0; cmd_color_i = '0;
`ifdef RECT_FILL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk_pix);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
    @(posedge clk_pix); #1;

    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i], 0, r);
      check($sformatf("v%0d_timeout", i), r.timeout, 0);
      check($sformatf("v%0d_writes", i), r.nwr, vecs[i].exp_n);
      check($sformatf("v%0d_addr_sum", i), r.sum, vecs[i].exp_sum);
      check($sformatf("v%0d_first", i), r.first, vecs[i].exp_first);
      check($sformatf("v%0d_last", i), r.last, vecs[i].exp_last);
      check($sformatf("v%0d_dones", i), r.dones, 1);
      check($sformatf("v%0d_sel_seen", i), (r.sel_lat >= 0) ? 1 : 0, (vecs[i].exp_n > 0) ? 1 : 0);
      check($sformatf("v%0d_latency", i), (vecs[i].exp_n > 0) ? r.sel_lat : r.done_lat, 2);
      check($sformatf("v%0d_hold", i), r.bad_hold, 0);
      check($sformatf("v%0d_gap", i), r.bad_gap, 0);
      check($sformatf("v%0d_data", i), r.bad_data, 0);
    end

    // Valid held through a busy command with changed fields: the new fields
    // must not disturb the running command and must be taken afterwards.
    cmd_x0_i = 12'd2; cmd_y0_i = 12'd0; cmd_x1_i = 12'd2; cmd_y1_i = 12'd0;
    cmd_color_i = 16'h0111; cmd_valid_i = 1'b1;
    @(posedge clk_pix); #1;
    cmd_x0_i = 12'd3; cmd_y0_i = 12'd1; cmd_x1_i = 12'd3; cmd_y1_i = 12'd1;
    cmd_color_i = 16'h0222;
    nwr = 0; dn = 0; drop = 0; a0 = -1; a1 = -1;
    for (int n = 0; n < 40; n++) begin
      if (done_o) dn++;
      if (vram_sel_o) begin
        vram_ack_i = 1'b1;
        if (nwr == 0) a0 = vram_addr_o; else a1 = vram_addr_o;
        nwr++;
      end else begin
        vram_ack_i = 1'b0;
      end
      if (cmd_valid_i && cmd_ready_o && dn == 1) drop = 1;
      @(posedge clk_pix); #1;
      if (drop == 1) cmd_valid_i = 1'b0;
    end
    vram_ack_i = 1'b0;
    cmd_valid_i = 1'b0;
    check("hold_valid_writes", nwr, 2);
    check("hold_valid_addr_a", a0, 2);
    check("hold_valid_addr_b", a1, 643);
    check("hold_valid_dones", dn, 2);

    // Reset during the third write of a 10-pixel row.
    cmd_x0_i = 12'd0; cmd_y0_i = 12'd0; cmd_x1_i = 12'd9; cmd_y1_i = 12'd0;
    cmd_color_i = 16'h0333; cmd_valid_i = 1'b1;
    @(posedge clk_pix); #1;
    cmd_valid_i = 1'b0;
    cnt = 0; found = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (vram_sel_o) begin
        cnt++;
        if (cnt == 3) begin found = 1'b1; break; end
        vram_ack_i = 1'b1;
      end else begin
        vram_ack_i = 1'b0;
      end
      @(posedge clk_pix); #1;
    end
    check("rst_mid_reach", found, 1);
    check("rst_mid_addr3", vram_addr_o, 2);
    vram_ack_i = 1'b0;
    reset = 1'b1;
    @(posedge clk_pix); #1;
    check_reset_vals("rst_mid");
    reset = 1'b0;
    dn = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk_pix); #1;
      if (done_o || vram_sel_o) dn++;
    end
    check("rst_mid_no_done", dn, 0);
    check("rst_mid_ready", cmd_ready_o, 1);

`ifdef RECT_FILL_ABORT_EN
    begin
      vec_t av;
      av = '{12'd0, 12'd0, 12'd99, 12'd0, 16'h0444, 1, 1'b0, 0, 0, 0, 0};
      run_cmd(av, 2, r);
      check("abort_timeout", r.timeout, 0);
      check("abort_acks", r.nwr, 2);
      check("abort_dones", r.dones, 1);
      check("abort_last", r.last, 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rect_fill_engine.md
RECT_FILL_ENGINE -- requirements
Module: rect_fill_engine

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 640, framebuffer width in pixels.
REQ-002 SHALL have parameter FB_HEIGHT, default 480, framebuffer height in pixels.
REQ-003 SHALL have port clk_pix  input  1  pixel clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid_i  input  1  fill command present.
REQ-006 SHALL have port cmd_ready_o  output  1  engine accepts command.
REQ-007 SHALL have ports cmd_x0_i, cmd_y0_i, cmd_x1_i, cmd_y1_i  input  12 each  inclusive rectangle corners.
REQ-008 SHALL have port cmd_color_i  input  16  fill colour, 4:4:4 in bits [11:0].
REQ-009 SHALL have port busy_o  output  1  command in progress.
REQ-010 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports vram_sel_o (output, 1), vram_wr_o (output, 1), vram_mask_o (output, 4), vram_addr_o (output, 32), vram_data_out_o (output, 16) and vram_ack_i (input, 1): framebuffer write port.

Function
REQ-012 SHALL use states IDLE, CLIP, REQ, GAP, DONE.
REQ-013 SHALL assert cmd_ready_o only in IDLE; a command is accepted and latched on a cycle with cmd_valid_i && cmd_ready_o; IDLE->CLIP.
REQ-014 SHALL, in CLIP, clamp x1 to min(x1, FB_WIDTH-1) and y1 to min(y1, FB_HEIGHT-1); rectangle is empty when x0>x1 or y0>y1 after the clamp.
REQ-015 SHALL go CLIP->DONE when the rectangle is empty, with no vram_sel_o pulse; otherwise CLIP->REQ, so the first vram_sel_o is high 2 cycles after acceptance.
REQ-016 SHALL, in REQ, hold vram_sel_o=1, vram_wr_o=1, vram_mask_o=4'b1111, vram_data_out_o=latched colour, and vram_addr_o=row_base+x, with all of these stable until vram_ack_i is sampled high.
REQ-017 SHALL, on ack in REQ, go to DONE if (x,y)=(x1,y1); otherwise go to GAP, deasserting vram_sel_o for exactly one cycle, then return to REQ.
REQ-018 SHALL advance in raster order: x increments; at x==x1, x reloads x0 and y increments.
REQ-019 SHALL keep row_base = y*FB_WIDTH by accumulation (+FB_WIDTH per row), with no multiplier; row_base is initialised to y0*FB_WIDTH in CLIP through iterative or constant-shift computation completed within CLIP.
REQ-020 SHALL zero-extend vram_addr_o to 32 bits; the address is a pixel (16-bit word) index.
REQ-021 SHALL assert done_o for exactly the one cycle spent in DONE, then go DONE->IDLE; busy_o = (state != IDLE).
REQ-022 SHALL ignore vram_ack_i outside REQ.
REQ-023 SHALL ignore cmd_valid_i while busy; the command is not lost if the source holds valid.

Reset
REQ-024 SHALL, on reset, set state=IDLE, cmd_ready_o=1, busy_o=0, done_o=0, vram_sel_o=0, vram_wr_o=0, vram_mask_o=0, vram_addr_o=0, vram_data_out_o=0 at the next edge.
REQ-025 SHALL abandon any in-flight request on reset mid-operation, with no done_o pulse.

Configuration
REQ-026 SHALL, with macro RECT_FILL_ABORT_EN defined, add input abort_i (1 bit): in CLIP/GAP it forces ->DONE next cycle; in REQ the engine waits for ack of the current write, then ->DONE; done_o pulses in both cases.
REQ-027 SHALL, without RECT_FILL_ABORT_EN, have no abort_i port and no abort logic.

Structure
REQ-028 SHALL place the state enum, CORDW=12 and VRAM_MASK_FULL=4'b1111 in shared package rect_fill_pkg.
REQ-029 SHALL implement the x/y counters and row_base accumulator as sub-module rect_fill_addr_gen.

Verification
REQ-030 SHALL cover: fill (0,0)-(1,1), colour 0x0F00, ack 1 cycle after sel -> 4 writes to addr 0,1,640,641, then one done_o pulse.
REQ-031 SHALL cover: fill (638,479)-(700,600) -> clipped to 2 writes at addr 307198 and 307199, then done_o.
REQ-032 SHALL cover: fill (10,5)-(3,5) -> done_o 2 cycles after acceptance, vram_sel_o never asserted.
REQ-033 SHALL cover: ack delayed 5 cycles -> addr, data and sel held stable for 5 cycles, one GAP cycle, next addr = previous+1.
REQ-034 SHALL cover: reset asserted during the 3rd write -> all outputs at reset values next cycle, no done_o, cmd_ready_o=1.
REQ-035 SHALL cover, with RECT_FILL_ABORT_EN: abort_i during REQ of pixel 2 of 100 -> exactly 2 acks consumed, then done_o.
